mem_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single request channel of the memory bus between `NUM_REQ` requesters (instruction fetch, load/store, DMA, …) and routes read responses back by `BusID`. It sits between the core-side clients and the memory bus, stamps each accepted request with the requester index as `source`, registers it into a one-entry output slot, and enforces a per-requester cap on outstanding reads.

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory request channel between requesters.
// Tracks outstanding reads per requester and routes responses by source id.
module mem_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_req_valid,
  output logic                      mem_req_write,
  output logic [ID_W-1:0]           mem_req_source,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_data,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [ID_W-1:0]           mem_rsp_source,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic                      mem_rsp_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      err_unexpected_rsp
);

  localparam int CNT_W = 3;

  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;
  logic               found;
  logic               grant;
  logic [ID_W-1:0]    win;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               src_ok;
  logic               cnt_nz;
  logic               rdy_sel;
  logic               rsp_hit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] &&
        (req_write[i] || out_cnt[i] < CNT_W'(MAX_OUT));
  end

  // Two passes: indices at or above rr_ptr first, then the wrap-around part
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && elig[i] && ID_W'(i) >= rr_ptr) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && elig[i] && ID_W'(i) < rr_ptr) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
  end

  assign grant = reset_n && found &&
                 (!mem_req_valid || mem_req_ready);

  always_comb begin
    req_ready = '0;
    inc       = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win == ID_W'(i));
      inc[i]       = req_ready[i] && !req_write[i];
      if (win == ID_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign src_ok = {1'b0, mem_rsp_source} < (ID_W+1)'(NUM_REQ);

  always_comb begin
    cnt_nz = 1'b0;
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (mem_rsp_source == ID_W'(i)) begin
        cnt_nz  = out_cnt[i] != '0;
        rdy_sel = rsp_ready[i];
      end
  end

  assign rsp_hit = src_ok && cnt_nz;
  assign rsp_data = mem_rsp_data;
  assign mem_rsp_ready = reset_n && (rsp_hit ? rdy_sel : 1'b1);

  always_comb begin
    rsp_valid = '0;
    dec       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = mem_rsp_valid && rsp_hit &&
                     (mem_rsp_source == ID_W'(i));
      dec[i]       = rsp_valid[i] && rsp_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_valid  <= 1'b0;
      mem_req_write  <= 1'b0;
      mem_req_source <= '0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      rr_ptr         <= '0;
    end else if (grant) begin
      mem_req_valid  <= 1'b1;
      mem_req_write  <= sel_write;
      mem_req_source <= win;
      mem_req_addr   <= sel_addr;
      mem_req_data   <= sel_data;
      rr_ptr <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        case ({inc[i], dec[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CNT_W'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CNT_W'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      err_unexpected_rsp <= 1'b0;
    else if (mem_rsp_valid && !rsp_hit)
      err_unexpected_rsp <= 1'b1;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grants, backpressure,
// outstanding-read cap, response routing and reset.
module tb_mem_bus_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_req_valid;
  logic                      mem_req_write;
  logic [ID_W-1:0]           mem_req_source;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic [DATA_W-1:0]         mem_req_data;
  logic                      mem_req_ready;
  logic                      mem_rsp_valid;
  logic [ID_W-1:0]           mem_rsp_source;
  logic [DATA_W-1:0]         mem_rsp_data;
  logic                      mem_rsp_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      err_unexpected_rsp;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUT(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write),
    .mem_req_source(mem_req_source),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_source(mem_rsp_source),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic w,
                         input logic [31:0] a,
                         input logic [63:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_source = '0;
    mem_rsp_data   = '0;
    rsp_ready      = '0;

    step();
    step();
    set_req(0, 1'b1, 1'b0, 32'h100, 64'h0);
    mid();
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    chk("rst_err", err_unexpected_rsp, 0);

    // round robin over writes
    step();
    reset_n = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, 1'b1, 32'h1000 + 32'(i*16),
              64'hA0 + 64'(i));
    for (int c = 0; c < 6; c++) begin
      mid();
      chk("rr_grant", req_ready, 64'(1 << (c % 3)));
      if (c > 0)
        chk("rr_src", mem_req_source, 64'((c - 1) % 3));
      step();
    end
    req_valid = '0;
    mid();
    chk("rr_last_src", mem_req_source, 2);
    chk("rr_last_write", mem_req_write, 1);
    chk("rr_last_data", mem_req_data, 64'hA2);

    // single read, ptr back at 0
    step();
    set_req(0, 1'b1, 1'b0, 32'h100, 64'h0);
    mid();
    chk("sr_grant", req_ready, 3'b001);
    step();
    req_valid = '0;
    mid();
    chk("sr_valid", mem_req_valid, 1);
    chk("sr_src", mem_req_source, 0);
    chk("sr_addr", mem_req_addr, 32'h100);
    chk("sr_write", mem_req_write, 0);
    step();
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 2'd0;
    mem_rsp_data   = 64'hDEAD;
    rsp_ready      = 3'b001;
    mid();
    chk("sr_drain", mem_req_valid, 0);
    chk("sr_rsp_valid", rsp_valid, 3'b001);
    chk("sr_rsp_data", rsp_data, 64'hDEAD);
    chk("sr_rsp_ready", mem_rsp_ready, 1);

    // backpressure, ptr at 1
    step();
    mem_rsp_valid = 1'b0;
    rsp_ready     = '0;
    mem_req_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, 1'b1, 32'h1000 + 32'(i*16),
              64'hA0 + 64'(i));
    mid();
    chk("bp_first", req_ready, 3'b010);
    step();
    set_req(1, 1'b1, 1'b1, 32'h5555, 64'h55);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("bp_ready", req_ready, 0);
      chk("bp_src", mem_req_source, 1);
      chk("bp_addr", mem_req_addr, 32'h1010);
      chk("bp_data", mem_req_data, 64'hA1);
      step();
    end
    mem_req_ready = 1'b1;
    mid();
    chk("bp_release", req_ready, 3'b100);
    step();
    req_valid = '0;
    mid();
    chk("bp_next_src", mem_req_source, 2);

    // outstanding cap on requester 1, ptr at 0
    step();
    set_req(1, 1'b1, 1'b0, 32'h200, 64'h0);
    mid();
    chk("cap_g1", req_ready, 3'b010);
    step();
    mid();
    chk("cap_g2", req_ready, 3'b010);
    step();
    mid();
    chk("cap_block", req_ready, 0);
    step();
    set_req(0, 1'b1, 1'b1, 32'h300, 64'h33);
    mid();
    chk("cap_other", req_ready, 3'b001);
    step();
    req_valid[0] = 1'b0;
    mid();
    chk("cap_block2", req_ready, 0);
    step();
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 2'd1;
    mem_rsp_data   = 64'hBEEF;
    rsp_ready      = 3'b010;
    mid();
    chk("cap_rsp", rsp_valid, 3'b010);
    chk("cap_still", req_ready, 0);
    step();
    mem_rsp_valid = 1'b0;
    rsp_ready     = '0;
    mid();
    chk("cap_regrant", req_ready, 3'b010);

    // unexpected responses
    step();
    req_valid      = '0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 2'd2;
    mid();
    chk("ux_err_pre", err_unexpected_rsp, 0);
    chk("ux2_ready", mem_rsp_ready, 1);
    chk("ux2_valid", rsp_valid, 0);
    step();
    mem_rsp_source = 2'd3;
    mid();
    chk("ux_err", err_unexpected_rsp, 1);
    chk("ux3_ready", mem_rsp_ready, 1);
    chk("ux3_valid", rsp_valid, 0);
    step();
    mem_rsp_source = 2'd0;
    mid();
    chk("ux0_ready", mem_rsp_ready, 1);
    chk("ux0_valid", rsp_valid, 0);
    step();
    mem_rsp_source = 2'd1;
    mid();
    chk("hit_valid", rsp_valid, 3'b010);
    chk("hit_ready", mem_rsp_ready, 0);
    step();
    mem_rsp_valid = 1'b0;
    mid();
    chk("err_hold", err_unexpected_rsp, 1);

    // reset mid-operation, ptr at 2
    step();
    mem_req_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h400, 64'h0);
    mid();
    chk("rm_grant", req_ready, 3'b001);
    step();
    req_valid = '0;
    reset_n   = 1'b0;
    mid();
    chk("rm_slot_pre", mem_req_valid, 1);
    step();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, 1'b1, 32'h700, 64'h7);
    mid();
    chk("rm_valid", mem_req_valid, 0);
    chk("rm_src", mem_req_source, 0);
    chk("rm_addr", mem_req_addr, 0);
    chk("rm_err", err_unexpected_rsp, 0);
    chk("rm_ready", req_ready, 0);
    chk("rm_rsp_ready", mem_rsp_ready, 0);
    step();
    reset_n = 1'b1;
    mem_req_ready = 1'b1;
    set_req(1, 1'b0, 1'b1, 32'h0, 64'h0);
    mid();
    chk("rm_lowest", req_ready, 3'b001);
    step();
    req_valid      = '0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 2'd0;
    rsp_ready      = 3'b000;
    mid();
    chk("rm_cnt_valid", rsp_valid, 0);
    chk("rm_cnt_ready", mem_rsp_ready, 1);
    step();
    mem_rsp_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
